// File: rtl/tomasulo_cdb_sch_if.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_cdb_sch_if
// Description : Bundle between reservation stations / execution units and the
//               CDB scheduler. Carries the request/grant handshake, the
//               writeback bus, the slot-reservation vector and the registered
//               common data bus {vld, tag, wdata}.
// Revision    : 1.0 - initial release
// ============================================================================
interface tomasulo_cdb_sch_if #(
    parameter int RS_N   = 3,
    parameter int SCH_N  = 8,
    parameter int LAT_W  = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
);
    localparam int CDB_W = 1 + TAG_W + DATA_W;

    // request / grant handshake
    logic [RS_N-1:0]        req;
    logic [RS_N*LAT_W-1:0]  req_lat;
    logic [RS_N-1:0]        gnt;

    // execution-unit writebacks
    logic [RS_N-1:0]        wb_vld;
    logic [RS_N*TAG_W-1:0]  wb_tag;
    logic [RS_N*DATA_W-1:0] wb_wdata;

    // scheduler state visible to every RS
    logic [SCH_N-1:0]       sch_r;
    logic [CDB_W-1:0]       cdb_r;    // {vld, tag, wdata}
    logic                   err_r;

    // reservation stations and execution units
    modport master (
        output req, req_lat, wb_vld, wb_tag, wb_wdata,
        input  gnt, sch_r, cdb_r, err_r
    );

    // the scheduler
    modport slave (
        input  req, req_lat, wb_vld, wb_tag, wb_wdata,
        output gnt, sch_r, cdb_r, err_r
    );
endinterface
`default_nettype wire

// File: rtl/tomasulo_cdb_sch.sv
`default_nettype none
// ============================================================================
// Module      : tomasulo_cdb_sch
// Description : CDB scheduler / arbiter. Grants one reservation station per
//               cycle a future CDB slot (same-cycle one-hot grant), tracks the
//               reserved slots in sch_r, and registers execution-unit
//               writebacks onto the common data bus. Flags collisions and
//               unscheduled writebacks in a sticky error bit.
//               Build option TOMASULO_CDB_SCH_RR_EN: round-robin arbitration;
//               when undefined, fixed priority (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module tomasulo_cdb_sch #(
    parameter int RS_N   = 3,
    parameter int SCH_N  = 8,
    parameter int LAT_W  = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    tomasulo_cdb_sch_if.slave  bus
);
    localparam int PTR_W = (RS_N > 1) ? $clog2(RS_N) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCH_N-1:0]  r_sch;
    logic              r_cdb_vld;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_wdata;
    logic              r_err;

    // ------------------------------------------------------------------
    // Per-RS latency unpack and eligibility
    // ------------------------------------------------------------------
    logic [LAT_W-1:0] w_lat [RS_N];
    logic [RS_N-1:0]  w_elig;

    // A latency of 0 or beyond the horizon can never be booked; the slot
    // L cycles ahead must still be free.
    for (genvar gi = 0; gi < RS_N; gi++) begin : g_rs
        assign w_lat[gi]  = bus.req_lat[gi*LAT_W +: LAT_W];
        assign w_elig[gi] = bus.req[gi]
                          && (w_lat[gi] != '0)
                          && (int'(w_lat[gi]) < SCH_N)
                          && !r_sch[w_lat[gi]];
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             w_gnt_any;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    logic [RS_N-1:0]  w_gnt;

`ifdef TOMASULO_CDB_SCH_RR_EN
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [RS_N-1:0]   w_rot;
    logic [PTR_W:0]    w_sum;
    logic [2*RS_N-1:0] w_dbl;

    // Rotate eligibility so the pointer lands on bit 0, pick the lowest
    // set bit, then rotate the winner's position back into RS numbering.
    always_comb begin
        w_dbl     = {w_elig, w_elig} >> r_rr_ptr;
        w_rot     = w_dbl[RS_N-1:0];
        w_gnt_any = 1'b0;
        w_sum     = '0;
        for (int k = 0; k < RS_N; k++) begin
            if (!w_gnt_any && w_rot[k]) begin
                w_gnt_any = 1'b1;
                w_sum     = (PTR_W+1)'(k) + {1'b0, r_rr_ptr};
            end
        end
        if (w_sum >= (PTR_W+1)'(RS_N)) begin
            w_sum = w_sum - (PTR_W+1)'(RS_N);
        end
        w_gnt_idx = w_sum[PTR_W-1:0];
    end

    // Pointer moves just past the last winner; holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= (w_gnt_idx == PTR_W'(RS_N-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`else
    // Fixed priority: the lowest-index eligible RS wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < RS_N; k++) begin
            if (!w_gnt_any && w_elig[k]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = PTR_W'(k);
            end
        end
    end
`endif

    // No grant may escape while the scheduler is being reset.
    assign w_gnt_vld = w_gnt_any && !rst;
    assign w_gnt     = w_gnt_vld ? (RS_N'(1) << w_gnt_idx) : '0;

    // ------------------------------------------------------------------
    // Slot booking
    // ------------------------------------------------------------------
    logic [LAT_W-1:0] w_gnt_lat;
    logic [SCH_N-1:0] w_slot;

    assign w_gnt_lat = w_lat[w_gnt_idx];

    // The vector shifts by one at the same edge, so a slot L cycles away
    // from the granting cycle lands on bit L-1.
    always_comb begin
        w_slot = '0;
        if (w_gnt_vld) begin
            w_slot[w_gnt_lat - 1'b1] = 1'b1;
        end
    end

    // Reservation vector: age every slot by one cycle and add the new booking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sch <= '0;
        end else begin
            r_sch <= (r_sch >> 1) | w_slot;
        end
    end

    // ------------------------------------------------------------------
    // Writeback mux and protocol checks
    // ------------------------------------------------------------------
    logic              w_wb_any;
    logic              w_wb_multi;
    logic              w_wb_unsched;
    logic [TAG_W-1:0]  w_wb_tag;
    logic [DATA_W-1:0] w_wb_wdata;

    // Scan from the top so the lowest asserted unit is the last to write.
    always_comb begin
        w_wb_tag   = '0;
        w_wb_wdata = '0;
        for (int i = RS_N-1; i >= 0; i--) begin
            if (bus.wb_vld[i]) begin
                w_wb_tag   = bus.wb_tag[i*TAG_W +: TAG_W];
                w_wb_wdata = bus.wb_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign w_wb_any     = |bus.wb_vld;
    assign w_wb_multi   = |(bus.wb_vld & (bus.wb_vld - 1'b1));
    assign w_wb_unsched = w_wb_any && !r_sch[1];

    // Registered CDB: valid follows writebacks, payload holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdb_vld   <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_wdata <= '0;
        end else begin
            r_cdb_vld <= w_wb_any;
            if (w_wb_any) begin
                r_cdb_tag   <= w_wb_tag;
                r_cdb_wdata <= w_wb_wdata;
            end
        end
    end

    // Sticky error: cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wb_multi || w_wb_unsched) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt   = w_gnt;
    assign bus.sch_r = r_sch;
    assign bus.cdb_r = {r_cdb_vld, r_cdb_tag, r_cdb_wdata};
    assign bus.err_r = r_err;

endmodule
`default_nettype wire
